cachepool_region_ctrl: RTL and testbench
========================================

CACHEPOOL_REGION_CTRL -- requirements
Module: cachepool_region_ctrl

Interface
REQ-001 SHALL have parameter NumRegions, default 4, meaning number of cached-region rules (>=1).
REQ-002 SHALL have parameter AddrWidth, default 32, meaning physical address width.
REQ-003 SHALL have parameter NumBanks, default 4, meaning number of L1 cache banks to flush on commit.
REQ-004 SHALL have parameter RstRules, default {0: base 0x8000_0000 mask 0x8000_0000 en 1; 1: base 0x5180_0000 mask 0xff80_0000 en 1; others 0}, meaning reset table.
REQ-005 SHALL have one clock and an asynchronous active-high reset: clk_i in 1 clock; rst_i in 1 async active-high reset.
REQ-006 cfg_valid_i in 1; cfg_ready_o out 1: rule-write handshake.
REQ-007 cfg_idx_i in clog2(NumRegions); cfg_base_i in AddrWidth; cfg_mask_i in AddrWidth; cfg_en_i in 1: rule write payload.
REQ-008 commit_i in 1: request to apply shadow table; commit_done_o out 1: one-cycle pulse at apply.
REQ-009 flush_req_o out NumBanks; flush_ack_i in NumBanks: per-bank flush handshake.
REQ-010 lookup_valid_i in 1; lookup_addr_i in AddrWidth: address query.
REQ-011 lookup_valid_o out 1; lookup_cached_o out 1; lookup_hit_idx_o out clog2(NumRegions): query result.
REQ-012 busy_o out 1: high whenever state != IDLE.

Function
REQ-013 SHALL hold two tables: shadow (written by cfg) and active (used by lookup), each NumRegions rules of {base, mask, en}.
REQ-014 cfg_ready_o SHALL be 1 only in IDLE; a write SHALL update shadow[cfg_idx_i] on the cycle valid&ready; writes do not touch active.
REQ-015 FSM states IDLE, FLUSH, COMMIT.
REQ-016 IDLE -> FLUSH when commit_i=1; commit_i in other states SHALL be ignored (no queueing).
REQ-017 commit_i and a cfg write in the same IDLE cycle: write SHALL land in shadow before the commit copy.
REQ-018 On FLUSH entry all flush_req_o bits SHALL rise the next cycle; bit b SHALL stay high until flush_ack_i[b] sampled high, then fall the next cycle and stay low for the rest of the operation.
REQ-019 Acks on banks whose req is low SHALL be ignored; acks may arrive in any order or simultaneously.
REQ-020 FLUSH -> COMMIT in the cycle after the last outstanding ack is sampled.
REQ-021 COMMIT SHALL last one cycle: active <= shadow, commit_done_o=1, then -> IDLE.
REQ-022 Commit latency: minimum 3 cycles from commit_i to commit_done_o (same-cycle acks).
REQ-023 Lookup: registered, 1-cycle latency; lookup_valid_o = lookup_valid_i delayed 1 cycle in every state.
REQ-024 Rule r matches iff en[r] and ((addr XOR base[r]) AND mask[r]) == 0; lookup_cached_o = any match; lookup_hit_idx_o = lowest matching index, 0 if none.
REQ-025 Lookups sampled while busy_o=1 SHALL return lookup_cached_o=0 (uncached) to avoid stale-line allocation.
REQ-026 Lookups sampled in the COMMIT cycle SHALL return 0; first lookup with the new table is the one sampled in the following IDLE cycle.
REQ-027 mask=0 with en=1 SHALL match every address.

Reset
REQ-028 While rst_i high: state IDLE, shadow and active = RstRules, flush_req_o=0, commit_done_o=0, lookup_valid_o=0, lookup_cached_o=0, lookup_hit_idx_o=0, busy_o=0, cfg_ready_o=1 after deassertion.
REQ-029 Reset mid-FLUSH SHALL abort the flush immediately with no commit; active reverts to RstRules.

Structure
REQ-030 region rule struct {base, mask, en} type and the default RstRules table SHALL live in cachepool_pkg, replacing the fixed two-rule function.
REQ-031 The match/priority logic SHALL be sub-module cachepool_region_match (combinational, one instance on active table).

Verification
REQ-032 Reset, lookup 0x8000_1000 -> next cycle valid=1, cached=1, idx=0; lookup 0x5180_0040 -> cached=1, idx=1; lookup 0x1000 -> cached=0.
REQ-033 Write idx2 base 0x4000_0000 mask 0xf000_0000 en 1, no commit; lookup 0x4000_0000 -> cached=0; commit, acks all same cycle -> done 3 cycles after commit_i; then lookup -> cached=1, idx=2.
REQ-034 NumBanks=4, acks staggered in order 3,0,2,1 at cycles +2,+4,+5,+9 -> each req falls one cycle after its ack, done exactly one cycle after COMMIT entry following last ack; cfg_ready_o=0 throughout.
REQ-035 Overlapping rules 0 and 1 (both matching 0x8180_0000) -> hit_idx=0; disable rule 0 and commit -> hit_idx=1.
REQ-036 Assert rst_i mid-FLUSH with shadow modified -> flush_req_o=0 immediately, no commit_done_o, active equals RstRules.
REQ-037 commit_i re-pulsed during FLUSH -> ignored, exactly one commit_done_o.

Source files
------------

// File: rtl/cachepool_pkg.sv
// Shared types for the cached-region controller: rule record, reset rule table
// and FSM state encoding.
package cachepool_pkg;

   localparam int unsigned MaxRegions   = 16;
   localparam int unsigned MaxAddrWidth = 64;

   typedef struct packed {
      logic [MaxAddrWidth-1:0] base;
      logic [MaxAddrWidth-1:0] mask;
      logic                    en;
   } region_rule_t;

   typedef region_rule_t [MaxRegions-1:0] rule_table_t;

   typedef enum logic [1:0] {
      StIdle,
      StFlush,
      StCommit
   } state_e;

   // Rule 0 caches the upper half of the address space, rule 1 the 8 MiB window at 0x5180_0000.
   function automatic rule_table_t default_rules();
      rule_table_t t;
      t    = '0;
      t[0] = '{base: 64'h8000_0000, mask: 64'h8000_0000, en: 1'b1};
      t[1] = '{base: 64'h5180_0000, mask: 64'hff80_0000, en: 1'b1};
      return t;
   endfunction

   localparam rule_table_t DefaultRules = default_rules();

endpackage

// File: rtl/cachepool_region_match.sv
// Combinational region match: a rule hits when enabled and the masked address bits
// equal its base; the lowest-numbered hit wins.
module cachepool_region_match #(
   parameter int unsigned NumRegions = 4,
   parameter int unsigned AddrWidth  = 32,
   parameter int unsigned IdxWidth   = 2
) (
   input  logic [NumRegions-1:0][AddrWidth-1:0] base,
   input  logic [NumRegions-1:0][AddrWidth-1:0] mask,
   input  logic [NumRegions-1:0]                en,
   input  logic [AddrWidth-1:0]                 addr,
   output logic                                 hit,
   output logic [IdxWidth-1:0]                  hit_idx
);

   // Scan high to low so the last assignment is the lowest matching index.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int r = NumRegions - 1; r >= 0; r--) begin
         if (en[r] && (((addr ^ base[r]) & mask[r]) == '0)) begin
            hit     = 1'b1;
            hit_idx = IdxWidth'(r);
         end
      end
   end

endmodule

// File: rtl/cachepool_region_ctrl.sv
// Cached-region rule controller: shadow table written by cfg, applied to the active
// lookup table only after every L1 bank has acknowledged a flush.
module cachepool_region_ctrl
   import cachepool_pkg::*;
#(
   parameter int unsigned NumRegions = 4,
   parameter int unsigned AddrWidth  = 32,
   parameter int unsigned NumBanks   = 4,
   parameter rule_table_t RstRules   = DefaultRules,
   localparam int unsigned IdxWidth  = (NumRegions > 1) ? $clog2(NumRegions) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cfg_valid_i,
   output logic                 cfg_ready_o,
   input  logic [IdxWidth-1:0]  cfg_idx_i,
   input  logic [AddrWidth-1:0] cfg_base_i,
   input  logic [AddrWidth-1:0] cfg_mask_i,
   input  logic                 cfg_en_i,
   input  logic                 commit_i,
   output logic                 commit_done_o,
   output logic [NumBanks-1:0]  flush_req_o,
   input  logic [NumBanks-1:0]  flush_ack_i,
   input  logic                 lookup_valid_i,
   input  logic [AddrWidth-1:0] lookup_addr_i,
   output logic                 lookup_valid_o,
   output logic                 lookup_cached_o,
   output logic [IdxWidth-1:0]  lookup_hit_idx_o,
   output logic                 busy_o
);

   state_e state, state_next;
   logic   flush_started;
   logic   cfg_write;
   logic   match_hit;
   logic   lookup_use;
   logic [IdxWidth-1:0] match_idx;

   logic [NumRegions-1:0][AddrWidth-1:0] shadow_base, shadow_mask;
   logic [NumRegions-1:0][AddrWidth-1:0] active_base, active_mask;
   logic [NumRegions-1:0]                shadow_en, active_en;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= StIdle;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         StIdle:   if (commit_i) state_next = StFlush;
         StFlush:  if (flush_started && ((flush_req_o & ~flush_ack_i) == '0)) state_next = StCommit;
         StCommit: state_next = StIdle;
         default:  state_next = StIdle;
      endcase
   end

   always_comb begin
      cfg_ready_o   = (state == StIdle);
      busy_o        = (state != StIdle);
      commit_done_o = (state == StCommit);
   end

   // Requests rise one cycle after FLUSH entry; acks only clear bits that are still high.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         flush_req_o   <= '0;
         flush_started <= 1'b0;
      end else if (state == StFlush) begin
         if (!flush_started) begin
            flush_req_o   <= '1;
            flush_started <= 1'b1;
         end else begin
            flush_req_o <= flush_req_o & ~flush_ack_i;
         end
      end else begin
         flush_req_o   <= '0;
         flush_started <= 1'b0;
      end
   end

   assign cfg_write = cfg_valid_i && cfg_ready_o && (32'(cfg_idx_i) < NumRegions);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int r = 0; r < NumRegions; r++) begin
            shadow_base[r] <= RstRules[r].base[AddrWidth-1:0];
            shadow_mask[r] <= RstRules[r].mask[AddrWidth-1:0];
            shadow_en[r]   <= RstRules[r].en;
            active_base[r] <= RstRules[r].base[AddrWidth-1:0];
            active_mask[r] <= RstRules[r].mask[AddrWidth-1:0];
            active_en[r]   <= RstRules[r].en;
         end
      end else begin
         if (cfg_write) begin
            shadow_base[cfg_idx_i] <= cfg_base_i;
            shadow_mask[cfg_idx_i] <= cfg_mask_i;
            shadow_en[cfg_idx_i]   <= cfg_en_i;
         end
         if (state == StCommit) begin
            active_base <= shadow_base;
            active_mask <= shadow_mask;
            active_en   <= shadow_en;
         end
      end
   end

   cachepool_region_match #(
      .NumRegions (NumRegions),
      .AddrWidth  (AddrWidth),
      .IdxWidth   (IdxWidth)
   ) u_match (
      .base    (active_base),
      .mask    (active_mask),
      .en      (active_en),
      .addr    (lookup_addr_i),
      .hit     (match_hit),
      .hit_idx (match_idx)
   );

   // Any lookup sampled outside IDLE reports uncached so no line is allocated on a stale table.
   assign lookup_use = lookup_valid_i && !busy_o && match_hit;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lookup_valid_o   <= 1'b0;
         lookup_cached_o  <= 1'b0;
         lookup_hit_idx_o <= '0;
      end else begin
         lookup_valid_o   <= lookup_valid_i;
         lookup_cached_o  <= lookup_use;
         lookup_hit_idx_o <= lookup_use ? match_idx : '0;
      end
   end

endmodule

// File: tb/tb_cachepool_region_ctrl.sv
// Directed bench for cachepool_region_ctrl: reset table lookups, shadow/commit flow,
// staggered flush acks, priority, catch-all rule and reset during flush.
module tb_cachepool_region_ctrl;

   logic        clk;
   logic        rst_i;
   logic        cfg_valid_i;
   logic        cfg_ready_o;
   logic [1:0]  cfg_idx_i;
   logic [31:0] cfg_base_i;
   logic [31:0] cfg_mask_i;
   logic        cfg_en_i;
   logic        commit_i;
   logic        commit_done_o;
   logic [3:0]  flush_req_o;
   logic [3:0]  flush_ack_i;
   logic        lookup_valid_i;
   logic [31:0] lookup_addr_i;
   logic        lookup_valid_o;
   logic        lookup_cached_o;
   logic [1:0]  lookup_hit_idx_o;
   logic        busy_o;

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;

   // Staggered-ack scenario, indexed by cycles after commit_i was sampled.
   logic [3:0] exp_req [0:12] = '{4'h0, 4'h0, 4'hF, 4'h7, 4'h7, 4'h6, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0};
   logic [3:0] ack_tab [0:12] = '{4'h0, 4'hF, 4'h8, 4'h0, 4'h1, 4'hC, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0};

   cachepool_region_ctrl dut (
      .clk_i            (clk),
      .rst_i            (rst_i),
      .cfg_valid_i      (cfg_valid_i),
      .cfg_ready_o      (cfg_ready_o),
      .cfg_idx_i        (cfg_idx_i),
      .cfg_base_i       (cfg_base_i),
      .cfg_mask_i       (cfg_mask_i),
      .cfg_en_i         (cfg_en_i),
      .commit_i         (commit_i),
      .commit_done_o    (commit_done_o),
      .flush_req_o      (flush_req_o),
      .flush_ack_i      (flush_ack_i),
      .lookup_valid_i   (lookup_valid_i),
      .lookup_addr_i    (lookup_addr_i),
      .lookup_valid_o   (lookup_valid_o),
      .lookup_cached_o  (lookup_cached_o),
      .lookup_hit_idx_o (lookup_hit_idx_o),
      .busy_o           (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lookup(input string tag, input logic [31:0] addr, input logic cached, input logic [1:0] idx);
      lookup_valid_i = 1'b1;
      lookup_addr_i  = addr;
      tick();
      lookup_valid_i = 1'b0;
      check({tag, "_valid"},  64'(lookup_valid_o),   64'(1));
      check({tag, "_cached"}, 64'(lookup_cached_o),  64'(cached));
      check({tag, "_idx"},    64'(lookup_hit_idx_o), 64'(idx));
   endtask

   task automatic cfg_write(input logic [1:0] idx, input logic [31:0] base, input logic [31:0] mask, input logic en);
      cfg_valid_i = 1'b1;
      cfg_idx_i   = idx;
      cfg_base_i  = base;
      cfg_mask_i  = mask;
      cfg_en_i    = en;
      tick();
      cfg_valid_i = 1'b0;
   endtask

   // Commit with all acks in the first request cycle; probes a lookup during COMMIT.
   task automatic commit_fast(input string tag, input logic [31:0] probe);
      commit_i = 1'b1;
      tick();
      commit_i    = 1'b0;
      cfg_valid_i = 1'b0;
      check({tag, "_busy_flush"}, 64'(busy_o), 64'(1));
      check({tag, "_req_first"},  64'(flush_req_o), 64'(0));
      check({tag, "_ready_low"},  64'(cfg_ready_o), 64'(0));
      tick();
      check({tag, "_req_all"}, 64'(flush_req_o), 64'(4'hF));
      flush_ack_i = 4'hF;
      tick();
      flush_ack_i    = 4'h0;
      check({tag, "_done"},     64'(commit_done_o), 64'(1));
      check({tag, "_req_done"}, 64'(flush_req_o),   64'(0));
      lookup_valid_i = 1'b1;
      lookup_addr_i  = probe;
      tick();
      lookup_valid_i = 1'b0;
      check({tag, "_done_off"},      64'(commit_done_o),   64'(0));
      check({tag, "_idle"},          64'(busy_o),          64'(0));
      check({tag, "_commit_lk_vld"}, 64'(lookup_valid_o),  64'(1));
      check({tag, "_commit_lk_unc"}, 64'(lookup_cached_o), 64'(0));
   endtask

   initial begin
      rst_i          = 1'b1;
      cfg_valid_i    = 1'b0;
      cfg_idx_i      = '0;
      cfg_base_i     = '0;
      cfg_mask_i     = '0;
      cfg_en_i       = 1'b0;
      commit_i       = 1'b0;
      flush_ack_i    = '0;
      lookup_valid_i = 1'b0;
      lookup_addr_i  = '0;

      tick();
      tick();
      check("rst_req",    64'(flush_req_o),      64'(0));
      check("rst_done",   64'(commit_done_o),    64'(0));
      check("rst_lkvld",  64'(lookup_valid_o),   64'(0));
      check("rst_cached", 64'(lookup_cached_o),  64'(0));
      check("rst_idx",    64'(lookup_hit_idx_o), 64'(0));
      check("rst_busy",   64'(busy_o),           64'(0));
      rst_i = 1'b0;
      tick();
      check("rst_ready", 64'(cfg_ready_o), 64'(1));
      check("idle_lkvld", 64'(lookup_valid_o), 64'(0));

      // Reset table
      lookup("lk_rule0", 32'h8000_1000, 1'b1, 2'd0);
      lookup("lk_rule1", 32'h5180_0040, 1'b1, 2'd1);
      lookup("lk_none",  32'h0000_1000, 1'b0, 2'd0);

      // Shadow write is invisible until commit
      cfg_write(2'd2, 32'h4000_0000, 32'hf000_0000, 1'b1);
      lookup("lk_shadow_only", 32'h4000_0000, 1'b0, 2'd0);
      commit_fast("c1", 32'h4000_0000);
      lookup("lk_rule2", 32'h4000_0000, 1'b1, 2'd2);

      // Staggered acks with commit re-pulsed during FLUSH and COMMIT
      commit_i = 1'b1;
      tick();
      commit_i = 1'b0;
      done_cnt = 0;
      for (int k = 1; k <= 12; k++) begin
         check($sformatf("stag_req_k%0d", k),   64'(flush_req_o),   64'(exp_req[k]));
         check($sformatf("stag_done_k%0d", k),  64'(commit_done_o), 64'(k == 10));
         check($sformatf("stag_busy_k%0d", k),  64'(busy_o),        64'(k <= 10));
         check($sformatf("stag_ready_k%0d", k), 64'(cfg_ready_o),   64'(k > 10));
         if (commit_done_o) done_cnt++;
         flush_ack_i = ack_tab[k];
         commit_i    = (k == 4) || (k == 10);
         tick();
         flush_ack_i = 4'h0;
         commit_i    = 1'b0;
      end
      check("stag_done_count", 64'(done_cnt), 64'(1));

      // Overlapping rules: lowest index wins, then rule 0 disabled
      cfg_write(2'd1, 32'h8180_0000, 32'hff80_0000, 1'b1);
      commit_fast("c2", 32'h8180_0000);
      lookup("lk_overlap", 32'h8180_0000, 1'b1, 2'd0);
      cfg_write(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
      // Catch-all rule written in the same cycle as commit_i
      cfg_valid_i = 1'b1;
      cfg_idx_i   = 2'd3;
      cfg_base_i  = 32'h1234_5678;
      cfg_mask_i  = 32'h0;
      cfg_en_i    = 1'b1;
      commit_fast("c3", 32'h8180_0000);
      lookup("lk_rule0_off", 32'h8180_0000, 1'b1, 2'd1);
      lookup("lk_catchall",  32'h0000_1000, 1'b1, 2'd3);

      // Reset during FLUSH with a modified shadow
      cfg_write(2'd2, 32'h0, 32'h0, 1'b0);
      commit_i = 1'b1;
      tick();
      commit_i = 1'b0;
      tick();
      check("rf_req_up", 64'(flush_req_o), 64'(4'hF));
      #2;
      rst_i = 1'b1;
      #1;
      check("rf_req_clr", 64'(flush_req_o),   64'(0));
      check("rf_busy",    64'(busy_o),        64'(0));
      check("rf_done",    64'(commit_done_o), 64'(0));
      tick();
      check("rf_done_hold", 64'(commit_done_o), 64'(0));
      rst_i = 1'b0;
      tick();
      check("rf_done_after", 64'(commit_done_o), 64'(0));
      lookup("rf_lk_rule0", 32'h8000_1000, 1'b1, 2'd0);
      lookup("rf_lk_rule1", 32'h5180_0040, 1'b1, 2'd1);
      lookup("rf_lk_none",  32'h0000_1000, 1'b0, 2'd0);
      lookup("rf_lk_rule2", 32'h4000_0000, 1'b0, 2'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
